// File: rtl/button_conditioner.sv
// button_conditioner: turns one raw, bouncing push-button into a debounced
// level plus single-cycle press/release strobes.
//   btn_raw -> two-flop synchronizer -> counter-based debounce FSM.
// Optional hold-to-auto-repeat is compiled in with `define BTN_AUTOREPEAT_EN;
// without it press_pulse fires exactly once per accepted press.
// fsm_state mirrors the debounce FSM state (IDLE=0, PRESS_WAIT=1, HELD=2,
// RELEASE_WAIT=3) for observation only.
`timescale 1ns/1ps

module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [1:0] fsm_state
);

    // Strobe semantics: press_pulse and release_pulse are registered,
    // high for exactly one clock, never high together, and carry no
    // handshake; the consumer must sample them on every clock.

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Count value on which the DEBOUNCE_CYCLES-th stable sample is seen.
    localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CYCLES - 1);

    logic        s1;
    logic        s2;
    logic        sync;
    state_t      state;
    state_t      state_nx;
    logic [31:0] cnt;
    logic [31:0] cnt_nx;
    logic        level_nx;
    logic        press_base_nx;
    logic        press_nx;
    logic        release_nx;

    assign sync      = s2;
    assign fsm_state = state;

    // Two-flop synchronizer for the asynchronous button pin.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // FSM state, debounce counter and registered outputs.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state         <= IDLE;
            cnt           <= 32'd0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            btn_level     <= level_nx;
            press_pulse   <= press_nx;
            release_pulse <= release_nx;
        end
    end

    // Debounce next-state logic: a level change is accepted only after
    // DEBOUNCE_CYCLES consecutive equal synchronized samples.
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        level_nx      = btn_level;
        press_base_nx = 1'b0;
        release_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (sync) begin
                    state_nx = PRESS_WAIT;
                    cnt_nx   = 32'd1;
                end else begin
                    cnt_nx   = 32'd0;
                end
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_nx = IDLE;
                    cnt_nx   = 32'd0;
                end else if (cnt == DB_LAST) begin
                    state_nx      = HELD;
                    cnt_nx        = 32'd0;
                    level_nx      = 1'b1;
                    press_base_nx = 1'b1;
                end else begin
                    cnt_nx   = cnt + 32'd1;
                end
            end
            HELD: begin
                if (!sync) begin
                    state_nx = RELEASE_WAIT;
                    cnt_nx   = 32'd1;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back high returns to HELD silently; level stays 1.
                if (sync) begin
                    state_nx = HELD;
                    cnt_nx   = 32'd0;
                end else if (cnt == DB_LAST) begin
                    state_nx   = IDLE;
                    cnt_nx     = 32'd0;
                    level_nx   = 1'b0;
                    release_nx = 1'b1;
                end else begin
                    cnt_nx     = cnt + 32'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 32'd0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    // Repeat fires on the edge where rpt would reach REPEAT_DELAY; reloading
    // to REPEAT_DELAY-REPEAT_PERIOD (mod 2^32) then spaces later repeats by
    // REPEAT_PERIOD HELD cycles. The reload wraps harmlessly when
    // REPEAT_PERIOD > REPEAT_DELAY.
    localparam logic [31:0] RPT_LAST   = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RPT_RELOAD = 32'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [31:0] rpt;
    logic [31:0] rpt_nx;
    logic        rpt_fire;

    // Repeat timer: cleared on acceptance, advances only in HELD,
    // frozen in every other state.
    always_comb begin
        rpt_nx   = rpt;
        rpt_fire = 1'b0;
        if (press_base_nx) begin
            rpt_nx = 32'd0;
        end else if (state == HELD) begin
            if (rpt == RPT_LAST) begin
                rpt_fire = 1'b1;
                rpt_nx   = RPT_RELOAD;
            end else begin
                rpt_nx   = rpt + 32'd1;
            end
        end
    end

    // Repeat timer register.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            rpt <= 32'd0;
        end else begin
            rpt <= rpt_nx;
        end
    end

    assign press_nx = press_base_nx | rpt_fire;
`else
    assign press_nx = press_base_nx;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed bench for button_conditioner with
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5. Expected pulses
// (kind + cycle) are queued as stimulus is issued; a monitor pops them
// whenever the DUT strobes. Build with +define+BTN_AUTOREPEAT_EN to
// exercise auto-repeat.
`timescale 1ns/1ps

module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;
    localparam int W  = 33;   // {is_press, cycle[31:0]}

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_raw = 1'b0;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic [1:0] fsm_state;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;
    logic [W-1:0] mon_got;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .CLK100MHZ    (clk),
        .CPU_RESETN   (rst_n),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .fsm_state    (fsm_state)
    );

    // Clock and edge counter: cyc is the number of rising edges so far.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // Driver tasks: inputs change 1 ns after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cycle(input int target);
        while (cyc < target) tick();
    endtask

    task automatic expect_pulse(input bit is_press, input int at);
        exp_q.push_back({is_press, 32'(at)});
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, req);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check_bit({name, "_level"}, btn_level, 1'b0);
        check_bit({name, "_press"}, press_pulse, 1'b0);
        check_bit({name, "_release"}, release_pulse, 1'b0);
    endtask

    // Scoreboard monitor: every strobe must match the head of exp_q.
    always @(posedge clk) begin
        #1;
        if (press_pulse && release_pulse) begin
            checks++;
            errors++;
            $display("FAIL pulse_exclusive at cycle %0d: press and release both high", cyc);
        end
        if (press_pulse || release_pulse) begin
            checks++;
            mon_got = {press_pulse, 32'(cyc)};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse at cycle %0d: press=%b release=%b, none expected",
                         cyc, press_pulse, release_pulse);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL pulse: got %s at cycle %0d, expected %s at cycle %0d",
                             mon_got[32] ? "press" : "release", mon_got[31:0],
                             mon_exp[32] ? "press" : "release", mon_exp[31:0]);
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        int e0;
        int p;
        int r;
        bit pat [12];
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset state, before and after clock edges.
        rst_n   = 1'b0;
        btn_raw = 1'b0;
        #1;
        check_outputs_zero("reset_initial");
        repeat (3) tick();
        check_outputs_zero("reset_clocked");
        check_bit("reset_state_idle", fsm_state == 2'd0, 1'b1);
        rst_n = 1'b1;

        // 1. Clean press and release.
        goto_cycle(10);
        e0 = cyc;
        btn_raw = 1'b1;
        expect_pulse(1'b1, e0 + 6);
`ifdef BTN_AUTOREPEAT_EN
        expect_pulse(1'b1, e0 + 16);
        expect_pulse(1'b1, e0 + 21);
        expect_pulse(1'b1, e0 + 26);
        expect_pulse(1'b1, e0 + 31);
`endif
        expect_pulse(1'b0, e0 + 36);
        goto_cycle(e0 + 5);
        check_bit("t1_level_before_press", btn_level, 1'b0);
        goto_cycle(e0 + 6);
        check_bit("t1_level_at_press", btn_level, 1'b1);
        goto_cycle(e0 + 30);
        btn_raw = 1'b0;
        goto_cycle(e0 + 35);
        check_bit("t1_level_before_release", btn_level, 1'b1);
        goto_cycle(e0 + 36);
        check_bit("t1_level_at_release", btn_level, 1'b0);
        goto_cycle(e0 + 45);

        // 2. Press bounce: only the final run of four 1s is accepted.
        e0 = cyc;
        expect_pulse(1'b1, e0 + 13);
        for (int k = 0; k < 12; k++) begin
            btn_raw = pat[k];
            tick();
        end
        check_bit("t2_level_before_press", btn_level, 1'b0);
        goto_cycle(e0 + 13);
        check_bit("t2_level_at_press", btn_level, 1'b1);
        p = e0 + 13;

        // 3. Release bounce while HELD, then a clean release.
        btn_raw = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        expect_pulse(1'b1, p + 12);
        expect_pulse(1'b1, p + 17);
        expect_pulse(1'b1, p + 22);
`endif
        expect_pulse(1'b0, p + 28);
        for (int c = p + 1; c <= p + 27; c++) begin
            goto_cycle(c);
            if (c == p + 2) btn_raw = 1'b1;
            if (c == p + 22) btn_raw = 1'b0;
            check_bit("t3_level_held", btn_level, 1'b1);
        end
        goto_cycle(p + 28);
        check_bit("t3_level_released", btn_level, 1'b0);
        goto_cycle(p + 36);

`ifdef BTN_AUTOREPEAT_EN
        // 4. Auto-repeat: press, then repeats every 5 after an initial 10.
        e0 = cyc;
        btn_raw = 1'b1;
        p = e0 + 6;
        expect_pulse(1'b1, p);
        for (int t = 10; t <= 40; t += 5) expect_pulse(1'b1, p + t);
        expect_pulse(1'b0, p + 46);
        goto_cycle(p + 40);
        check_bit("t4_level_held", btn_level, 1'b1);
        btn_raw = 1'b0;
        goto_cycle(p + 46);
        check_bit("t4_level_released", btn_level, 1'b0);
        goto_cycle(p + 52);
`else
        // 6. Long hold without auto-repeat: exactly one press_pulse.
        e0 = cyc;
        btn_raw = 1'b1;
        expect_pulse(1'b1, e0 + 6);
        expect_pulse(1'b0, e0 + 1006);
        for (int c = e0 + 6; c <= e0 + 1005; c++) begin
            goto_cycle(c);
            check_bit("t6_level_held", btn_level, 1'b1);
            if (c == e0 + 1000) btn_raw = 1'b0;
        end
        goto_cycle(e0 + 1006);
        check_bit("t6_level_released", btn_level, 1'b0);
        goto_cycle(e0 + 1015);
`endif

        // 5. Asynchronous reset while HELD, button kept high.
        e0 = cyc;
        btn_raw = 1'b1;
        expect_pulse(1'b1, e0 + 6);
        goto_cycle(e0 + 8);
        check_bit("t5_level_before_reset", btn_level, 1'b1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t5_async_reset");
        check_bit("t5_state_idle", fsm_state == 2'd0, 1'b1);
        goto_cycle(e0 + 11);
        check_outputs_zero("t5_reset_held");
        rst_n = 1'b1;
        r = cyc;
        expect_pulse(1'b1, r + 6);
        expect_pulse(1'b0, r + 14);
        goto_cycle(r + 5);
        check_bit("t5_level_before_repress", btn_level, 1'b0);
        goto_cycle(r + 6);
        check_bit("t5_level_at_repress", btn_level, 1'b1);
        goto_cycle(r + 8);
        btn_raw = 1'b0;
        goto_cycle(r + 14);
        check_bit("t5_level_released", btn_level, 1'b0);
        goto_cycle(r + 20);

        // Final report.
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses: %0d expected pulses never seen, expected 0",
                     exp_q.size());
        end
        check_bit("end_state_idle", fsm_state == 2'd0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
